fetch_unit: RTL and testbench

- Instruction-fetch and instruction-register stage that sits directly upstream of the control-step timer.
- Holds the PC, the IR and the second-word operand register.
- Drives the synchronous instruction memory, paced by the timer's 3-bit phase code.
- Supplies the 16-bit instruction word the timer decodes; the bypass below ensures the timer sees the new word in its decode phase.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/fetch_unit_if.sv | 16 +
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_pkg: timer phase codes, fetch defaults and opcode constants.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  typedef enum logic [2:0] {
    PH_FETCH   = 3'b000,
    PH_DECODE  = 3'b001,
    PH_EXEC2   = 3'b010,
    PH_EXEC1   = 3'b011,
    PH_INIT    = 3'b100,
    PH_OPFETCH = 3'b101,
    PH_ILLEGAL = 3'b110,
    PH_OPLOAD  = 3'b111
  } phase_t;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [7:0]  OP_EXT2          = 8'h84;

  function automatic logic [15:0] pc_inc(input logic [15:0] v);
    return v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// +--------------------------------------------------------------------+
// | fetch_unit_if: synchronous instruction-memory read bus.            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface fetch_unit_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;

  modport master (output mem_addr, output mem_rd, input mem_rdata);
  modport slave  (input mem_addr, input mem_rd, output mem_rdata);
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// +--------------------------------------------------------------------+
// | fetch_unit: PC, IR and operand registers paced by the timer phase. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          PHASE_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PHASE_W-1:0] t_state,
  fetch_unit_if.master       mem,
  input  logic               branch_en,
  input  logic [15:0]        branch_target,
  output logic [15:0]        ins,
  output logic [15:0]        ir,
  output logic [15:0]        operand,
  output logic [15:0]        pc,
  output logic [15:0]        instr_count,
  output logic               phase_err
);

  phase_t      ph;
  logic [15:0] pc_nxt;
  logic [15:0] ir_nxt;
  logic [15:0] operand_nxt;
  logic [15:0] count_nxt;
  logic        err_nxt;

  assign ph = phase_t'(t_state);

  always_comb begin
    mem.mem_rd   = reset && ((ph == PH_FETCH) || (ph == PH_OPFETCH));
    mem.mem_addr = pc;
    // Bypass lets the timer decode the word still arriving from memory.
    ins          = (ph == PH_DECODE) ? mem.mem_rdata : ir;
  end

  always_comb begin
    pc_nxt      = pc;
    ir_nxt      = ir;
    operand_nxt = operand;
    count_nxt   = instr_count;
    err_nxt     = phase_err;
    case (ph)
      PH_DECODE: begin
        ir_nxt    = mem.mem_rdata;
        pc_nxt    = pc_inc(pc);
        count_nxt = instr_count + 16'd1;
      end
      PH_EXEC1, PH_EXEC2: begin
        if (branch_en) pc_nxt = branch_target;
      end
      PH_OPLOAD: begin
        operand_nxt = mem.mem_rdata;
        pc_nxt      = branch_en ? branch_target : pc_inc(pc);
      end
      PH_ILLEGAL: err_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      ir          <= 16'h0000;
      operand     <= 16'h0000;
      instr_count <= 16'h0000;
      phase_err   <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      ir          <= ir_nxt;
      operand     <= operand_nxt;
      instr_count <= count_nxt;
      phase_err   <= err_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// +--------------------------------------------------------------------+
// | tb_fetch_unit: directed vector table plus wrap and reset checks.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, reset_w;
  logic [2:0]  t_state, t_state_w;
  logic        branch_en;
  logic [15:0] branch_target;
  logic [15:0] ins, ir, operand, pc, instr_count;
  logic        phase_err;
  logic [15:0] ins_w, ir_w, operand_w, pc_w, count_w;
  logic        err_w;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] mem   [16];
  logic [15:0] mem_w [16];

  fetch_unit_if bus();
  fetch_unit_if bus_w();

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0000), .PHASE_W(3)) dut (
    .clk(clk), .reset(reset), .t_state(t_state), .mem(bus),
    .branch_en(branch_en), .branch_target(branch_target),
    .ins(ins), .ir(ir), .operand(operand), .pc(pc),
    .instr_count(instr_count), .phase_err(phase_err)
  );

  fetch_unit #(.RESET_PC(16'hFFFF), .PHASE_W(3)) dut_w (
    .clk(clk), .reset(reset_w), .t_state(t_state_w), .mem(bus_w),
    .branch_en(1'b0), .branch_target(16'h0000),
    .ins(ins_w), .ir(ir_w), .operand(operand_w), .pc(pc_w),
    .instr_count(count_w), .phase_err(err_w)
  );

  // One-cycle-latency synchronous memories.
  always @(posedge clk) if (bus.mem_rd)   bus.mem_rdata   <= mem[bus.mem_addr[3:0]];
  always @(posedge clk) if (bus_w.mem_rd) bus_w.mem_rdata <= mem_w[bus_w.mem_addr[3:0]];

  typedef struct {
    logic        rst;
    logic [2:0]  ph;
    logic        br;
    logic [15:0] tgt;
    logic        e_rd;
    logic [15:0] e_addr;
    logic [15:0] e_ins;
    logic [15:0] e_pc;
    logic [15:0] e_ir;
    logic [15:0] e_op;
    logic [15:0] e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]   = 16'h0000;
      mem_w[i] = 16'h0000;
    end
    mem[0] = 16'h1234; mem[1] = 16'h8400; mem[2] = 16'hBEEF;
    mem[3] = 16'h8400; mem[4] = 16'hCAFE; mem[7] = 16'h5A5A;
    mem[8] = 16'h0101; mem[9] = 16'h7777;
    mem_w[15] = 16'hABCD;

    //            rst  ph     br  tgt       rd  addr      ins       pc        ir        op        cnt       err
    vq.push_back('{1, 3'b000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0});
    vq.push_back('{1, 3'b001, 0, 16'h0000, 0, 16'h0000, 16'h1234, 16'h0001, 16'h1234, 16'h0000, 16'h0001, 0});
    vq.push_back('{1, 3'b011, 0, 16'h0000, 0, 16'h0001, 16'h1234, 16'h0001, 16'h1234, 16'h0000, 16'h0001, 0});
    vq.push_back('{1, 3'b000, 0, 16'h0000, 1, 16'h0001, 16'h1234, 16'h0001, 16'h1234, 16'h0000, 16'h0001, 0});
    vq.push_back('{1, 3'b001, 0, 16'h0000, 0, 16'h0001, 16'h8400, 16'h0002, 16'h8400, 16'h0000, 16'h0002, 0});
    vq.push_back('{1, 3'b101, 0, 16'h0000, 1, 16'h0002, 16'h8400, 16'h0002, 16'h8400, 16'h0000, 16'h0002, 0});
    vq.push_back('{1, 3'b111, 0, 16'h0000, 0, 16'h0002, 16'h8400, 16'h0003, 16'h8400, 16'hBEEF, 16'h0002, 0});
    vq.push_back('{1, 3'b010, 0, 16'h0000, 0, 16'h0003, 16'h8400, 16'h0003, 16'h8400, 16'hBEEF, 16'h0002, 0});
    // Branch wins over increment in opload, operand still captured.
    vq.push_back('{1, 3'b000, 0, 16'h0000, 1, 16'h0003, 16'h8400, 16'h0003, 16'h8400, 16'hBEEF, 16'h0002, 0});
    vq.push_back('{1, 3'b001, 0, 16'h0000, 0, 16'h0003, 16'h8400, 16'h0004, 16'h8400, 16'hBEEF, 16'h0003, 0});
    vq.push_back('{1, 3'b101, 0, 16'h0000, 1, 16'h0004, 16'h8400, 16'h0004, 16'h8400, 16'hBEEF, 16'h0003, 0});
    vq.push_back('{1, 3'b111, 1, 16'h0040, 0, 16'h0004, 16'h8400, 16'h0040, 16'h8400, 16'hCAFE, 16'h0003, 0});
    vq.push_back('{1, 3'b010, 1, 16'h0005, 0, 16'h0040, 16'h8400, 16'h0005, 16'h8400, 16'hCAFE, 16'h0003, 0});
    vq.push_back('{1, 3'b011, 1, 16'h0007, 0, 16'h0005, 16'h8400, 16'h0007, 16'h8400, 16'hCAFE, 16'h0003, 0});
    // Branch ignored in fetch, decode, opfetch, init, illegal.
    vq.push_back('{1, 3'b000, 1, 16'h0099, 1, 16'h0007, 16'h8400, 16'h0007, 16'h8400, 16'hCAFE, 16'h0003, 0});
    vq.push_back('{1, 3'b001, 1, 16'h0099, 0, 16'h0007, 16'h5A5A, 16'h0008, 16'h5A5A, 16'hCAFE, 16'h0004, 0});
    vq.push_back('{1, 3'b101, 1, 16'h0099, 1, 16'h0008, 16'h5A5A, 16'h0008, 16'h5A5A, 16'hCAFE, 16'h0004, 0});
    vq.push_back('{1, 3'b100, 1, 16'h0099, 0, 16'h0008, 16'h5A5A, 16'h0008, 16'h5A5A, 16'hCAFE, 16'h0004, 0});
    vq.push_back('{1, 3'b110, 1, 16'h0099, 0, 16'h0008, 16'h5A5A, 16'h0008, 16'h5A5A, 16'hCAFE, 16'h0004, 1});
    vq.push_back('{1, 3'b000, 0, 16'h0000, 1, 16'h0008, 16'h5A5A, 16'h0008, 16'h5A5A, 16'hCAFE, 16'h0004, 1});
    vq.push_back('{1, 3'b001, 0, 16'h0000, 0, 16'h0008, 16'h0101, 16'h0009, 16'h0101, 16'hCAFE, 16'h0005, 1});
    vq.push_back('{1, 3'b101, 0, 16'h0000, 1, 16'h0009, 16'h0101, 16'h0009, 16'h0101, 16'hCAFE, 16'h0005, 1});
    // Reset during opload discards the operand capture and the branch.
    vq.push_back('{0, 3'b111, 1, 16'h0040, 0, 16'h0009, 16'h0101, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0});
    vq.push_back('{1, 3'b100, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0});

    reset = 1'b0; reset_w = 1'b0;
    t_state = 3'b100; t_state_w = 3'b100;
    branch_en = 1'b0; branch_target = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; reset_w = 1'b1;
    #2;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_op", operand, 16'h0000);
    chk("rst_cnt", instr_count, 16'h0000);
    chk("rst_err", 16'(phase_err), 16'h0000);
    chk("rst_rd", 16'(bus.mem_rd), 16'h0000);
    chk("rst_pc_w", pc_w, 16'hFFFF);

    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst; t_state = vq[i].ph;
      branch_en = vq[i].br; branch_target = vq[i].tgt;
      #2;
      chk($sformatf("v%0d_rd", i), 16'(bus.mem_rd), 16'(vq[i].e_rd));
      chk($sformatf("v%0d_addr", i), bus.mem_addr, vq[i].e_addr);
      chk($sformatf("v%0d_ins", i), ins, vq[i].e_ins);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pc", i), pc, vq[i].e_pc);
      chk($sformatf("v%0d_ir", i), ir, vq[i].e_ir);
      chk($sformatf("v%0d_op", i), operand, vq[i].e_op);
      chk($sformatf("v%0d_cnt", i), instr_count, vq[i].e_cnt);
      chk($sformatf("v%0d_err", i), 16'(phase_err), 16'(vq[i].e_err));
    end

    // PC wrap from RESET_PC=FFFF on the second instance.
    @(negedge clk);
    t_state_w = 3'b000;
    #2;
    chk("w_rd", 16'(bus_w.mem_rd), 16'h0001);
    chk("w_addr", bus_w.mem_addr, 16'hFFFF);
    @(negedge clk);
    t_state_w = 3'b001;
    @(posedge clk); #1;
    chk("w_pc", pc_w, 16'h0000);
    chk("w_ir", ir_w, 16'hABCD);
    chk("w_cnt", count_w, 16'h0001);
    t_state_w = 3'b100;

    // Instruction counter wrap: decode every cycle from a zero count.
    @(negedge clk);
    branch_en = 1'b0;
    t_state = 3'b001;
    repeat (65535) @(posedge clk);
    #1;
    chk("cnt_ffff", instr_count, 16'hFFFF);
    chk("pc_ffff", pc, 16'hFFFF);
    @(posedge clk); #1;
    chk("cnt_wrap", instr_count, 16'h0000);
    chk("pc_wrap", pc, 16'h0000);
    chk("err_clear", 16'(phase_err), 16'h0000);
    t_state = 3'b100;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
